polo_msg_tx: RTL

//  Downstream of the "MARCO" comparator: on a one-cycle send pulse, transmits a fixed reply

---
 rtl/polo_pkg.sv | 33 +++
 rtl/uart_frame_shifter.sv | 65 ++++++
 rtl/polo_msg_tx.sv | 112 +++++++++++
 3 files changed

// File: rtl/polo_pkg.sv
// Shared definitions for the POLO reply transmitter.
//  - state_t    : 3-bit state encoding used by the sequencer and the frame shifter
//  - MSG_LEN    : number of bytes in the reply
//  - FRAME_BITS : baud periods per 8N1 frame (start + 8 data + stop)
//  - msg_byte() : reply ROM, "POLO\r\n"
package polo_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ARM   = 3'd1,
    ST_START = 3'd2,
    ST_DATA  = 3'd3,
    ST_STOP  = 3'd4,
    ST_GAP   = 3'd5
  } state_t;

  localparam int MSG_LEN    = 6;
  localparam int FRAME_BITS = 10;
  localparam int IDX_W      = 3;

  function automatic logic [7:0] msg_byte(input logic [IDX_W-1:0] idx);
    case (idx)
      3'd0:    msg_byte = 8'h50;  // 'P'
      3'd1:    msg_byte = 8'h4F;  // 'O'
      3'd2:    msg_byte = 8'h4C;  // 'L'
      3'd3:    msg_byte = 8'h4F;  // 'O'
      3'd4:    msg_byte = 8'h0D;  // CR
      3'd5:    msg_byte = 8'h0A;  // LF
      default: msg_byte = 8'h00;
    endcase
  endfunction

endpackage

// File: rtl/uart_frame_shifter.sv
// 8N1 frame serializer.
//  clk, rst_n  : clock, async active-low reset
//  tick        : baud strobe, one per bit period
//  load, data  : start a new frame with this byte (only asserted together with tick)
//  tx          : registered serial line, idle high
//  frame_done  : strobe on the tick that ends the stop bit
// A load on the stop-ending tick chains the next frame with no idle period.
module uart_frame_shifter (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] data,
  output logic       tx,
  output logic       frame_done
);
  import polo_pkg::*;

  localparam logic [3:0] DATA_BITS = 4'(FRAME_BITS - 2);

  state_t      state;
  logic [7:0]  shift;
  logic [3:0]  bit_cnt;

  assign frame_done = tick && (state == ST_STOP);

  // NOTE: reset is asynchronous and clears every flop; the ROM is constant logic, so
  // there is no storage array that would need (or avoid) a reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= ST_IDLE;
      shift   <= '0;
      bit_cnt <= '0;
      tx      <= 1'b1;
    end else if (load) begin
      // NOTE: non-blocking assignments, so every register here sees pre-edge values.
      shift   <= data;
      bit_cnt <= '0;
      tx      <= 1'b0;
      state   <= ST_START;
    end else if (tick) begin
      case (state)
        ST_START: begin
          tx      <= shift[0];
          shift   <= {1'b0, shift[7:1]};
          bit_cnt <= 4'd1;
          state   <= ST_DATA;
        end
        ST_DATA: begin
          if (bit_cnt < DATA_BITS) begin
            tx      <= shift[0];
            shift   <= {1'b0, shift[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end else begin
            tx    <= 1'b1;
            state <= ST_STOP;
          end
        end
        ST_STOP: state <= ST_IDLE;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/polo_msg_tx.sv
// Sends "POLO\r\n" as back-to-back 8N1 frames on each send request.
//  clk, rst_n : clock, async active-low reset
//  baud_tick  : one-clk strobe per bit period
//  send       : request pulse; a request while busy is held in a single pending slot
//  tx         : serial line (registered, idle high)
//  busy       : high from request acceptance until the last frame (plus gap) ends
//  done       : one-clk pulse at the end of each message
// The sequencer walks IDLE -> ARM -> START (frame in the shifter) [-> GAP] per byte.
module polo_msg_tx #(
  parameter int GAP_BITS = 0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic baud_tick,
  input  logic send,
  output logic tx,
  output logic busy,
  output logic done
);
  import polo_pkg::*;

  localparam logic [3:0]       GAP_LAST = 4'((GAP_BITS > 0) ? GAP_BITS - 1 : 0);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(MSG_LEN - 1);

  state_t           seq;
  logic [IDX_W-1:0] byte_idx;
  logic [3:0]       gap_cnt;
  logic             pending;
  logic             send_q;

  logic             send_req;
  logic             last_byte;
  logic             end_byte;
  logic             load;
  logic [IDX_W-1:0] load_idx;
  logic [7:0]       load_data;
  logic             frame_done;

  // A held send counts once: only its first cycle is a request.
  always_comb begin
    // NOTE: every variable gets a default first, so no path can infer a latch.
    send_req  = send & ~send_q;
    last_byte = (byte_idx == LAST_IDX);
    end_byte  = 1'b0;
    if (seq == ST_START && frame_done && GAP_BITS == 0) end_byte = 1'b1;
    if (seq == ST_GAP && baud_tick && gap_cnt == GAP_LAST) end_byte = 1'b1;
    load      = (seq == ST_ARM && baud_tick) || (end_byte && !last_byte);
    load_idx  = (seq == ST_ARM) ? byte_idx : byte_idx + IDX_W'(1);
    load_data = msg_byte(load_idx);
  end

  uart_frame_shifter u_shifter (
    .clk        (clk),
    .rst_n      (rst_n),
    .tick       (baud_tick),
    .load       (load),
    .data       (load_data),
    .tx         (tx),
    .frame_done (frame_done)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seq      <= ST_IDLE;
      byte_idx <= '0;
      gap_cnt  <= '0;
      pending  <= 1'b0;
      send_q   <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
    end else begin
      send_q <= send;
      done   <= 1'b0;
      if (seq != ST_IDLE && send_req) pending <= 1'b1;

      case (seq)
        // baud_tick is ignored here, so a tick coinciding with send is not used.
        ST_IDLE: if (send_req) begin
          seq  <= ST_ARM;
          busy <= 1'b1;
        end
        ST_ARM:  if (baud_tick) seq <= ST_START;
        ST_START: if (frame_done && GAP_BITS > 0) begin
          seq     <= ST_GAP;
          gap_cnt <= '0;
        end
        ST_GAP:  if (baud_tick) gap_cnt <= gap_cnt + 4'd1;
        default: seq <= ST_IDLE;
      endcase

      // End of byte overrides the per-state moves above.
      if (end_byte) begin
        if (!last_byte) begin
          byte_idx <= byte_idx + IDX_W'(1);
          seq      <= ST_START;
        end else begin
          byte_idx <= '0;
          done     <= 1'b1;
          // A request landing on the final tick replays just like a pending one.
          if (pending || send_req) begin
            pending <= 1'b0;
            seq     <= ST_ARM;
          end else begin
            busy <= 1'b0;
            seq  <= ST_IDLE;
          end
        end
      end
    end
  end

endmodule
